// File: rtl/sw_debounce_pkg.sv
// Shared constants and helpers for the switch debounce front end.
package sw_debounce_pkg;

  // Number of data switches feeding the priority encoder.
  localparam int SW_N = 8;

  // 10 ms at 100 MHz.
  localparam int DEB_CYCLES_DEF = 1_000_000;

  // Counter width able to hold 0 .. DEB_CYCLES-1 (and never wrap).
  function automatic int cnt_w(input int deb_cycles);
    return $clog2(deb_cycles + 1);
  endfunction

endpackage

// File: rtl/sw_debounce_if.sv
// Raw switch inputs and conditioned outputs toward the encoder.
interface sw_debounce_if;

  logic [sw_debounce_pkg::SW_N-1:0] sw;     // raw data switches, async
  logic                             en_sw;  // raw enable switch, async
  logic [sw_debounce_pkg::SW_N-1:0] x;      // debounced data
  logic                             en;     // debounced enable
  logic                             chg;    // 1-cycle pulse on new x

  // Board / stimulus side drives raw switches.
  modport master (
    output sw, en_sw,
    input  x, en, chg
  );

  // Debouncer side conditions them.
  modport slave (
    input  sw, en_sw,
    output x, en, chg
  );

endinterface

// File: rtl/sw_debounce_bit.sv
// One debounce channel: 2-flop synchroniser, mismatch counter, stable bit.
// upd is combinational and marks the edge on which q takes the new value.
module debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = cnt_w(DEB_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic upd
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             s1;   // may go metastable; only s2 reads it
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             diff;

  assign diff = (s2 != q);
  assign upd  = diff && (cnt == CNT_MAX);

  // Bring the raw switch into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  // Count consecutive mismatches; any matching cycle restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (!diff) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      q   <= s2;
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// Switch conditioning ahead of the priority encoder: eight data channels
// plus the enable channel, each synchronised and debounced independently.
// chg pulses for one cycle alongside the first cycle of any new x value;
// enable updates are deliberately excluded from chg.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = cnt_w(DEB_CYCLES)
) (
  input  logic              clk,
  input  logic              rst_n,
  sw_debounce_if.slave      bus
);

  logic [SW_N-1:0] x_q;
  logic [SW_N-1:0] upd;
  logic            en_q;
  logic            en_upd;
  logic            chg_q;

  for (genvar g = 0; g < SW_N; g++) begin : g_data
    debounce_bit #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
    ) u_bit (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.sw[g]),
      .q     (x_q[g]),
      .upd   (upd[g])
    );
  end

  debounce_bit #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_en (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.en_sw),
    .q     (en_q),
    .upd   (en_upd)
  );

  // Register the OR of data strobes so chg lines up with the new x.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chg_q <= 1'b0;
    else        chg_q <= |upd;
  end

  assign bus.x   = x_q;
  assign bus.en  = en_q;
  assign bus.chg = chg_q;

  // The enable strobe has no consumer here; keep it visible for debug.
  logic unused_en_upd;
  assign unused_en_upd = en_upd;

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce with DEB_CYCLES=4: directed latency scenarios plus
// a randomized run checked against a window-based reference model.
module tb_sw_debounce;
  import sw_debounce_pkg::*;

  localparam int DEB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sw_debounce_if bus();

  sw_debounce #(.DEB_CYCLES(DEB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model: the value compared at edge t is the raw input seen
  // at edge t-2; a channel flips when its last DEB compared samples all
  // differ from its current output.
  logic [8:0] raw_h[$];
  logic [8:0] cmp_h[$];
  logic [7:0] m_x   = '0;
  logic       m_en  = 1'b0;
  logic       m_chg = 1'b0;

  task automatic model_edge();
    logic [8:0] c, st, smp;
    logic [7:0] flip;
    bit         all;
    if (!rst_n) begin
      raw_h.delete(); cmp_h.delete();
      m_x = '0; m_en = 1'b0; m_chg = 1'b0;
      return;
    end
    raw_h.push_back({bus.en_sw, bus.sw});
    c = (raw_h.size() >= 3) ? raw_h[raw_h.size()-3] : 9'h0;
    cmp_h.push_back(c);
    st   = {m_en, m_x};
    flip = '0;
    for (int ch = 0; ch < 9; ch++) begin
      all = (cmp_h.size() >= DEB);
      for (int k = 0; k < DEB && all; k++) begin
        smp = cmp_h[cmp_h.size()-1-k];
        if (smp[ch] == st[ch]) all = 0;
      end
      if (all) begin
        st[ch] = ~st[ch];
        if (ch < 8) flip[ch] = 1'b1;
      end
    end
    m_x = st[7:0]; m_en = st[8]; m_chg = |flip;
    if (raw_h.size() > 8) void'(raw_h.pop_front());
    if (cmp_h.size() > 8) void'(cmp_h.pop_front());
  endtask

  // One clock edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic settle();
    bus.sw = 8'h00; bus.en_sw = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    bus.sw = 8'hFF; bus.en_sw = 1'b1; rst_n = 1'b0;
    repeat (3) begin
      tick();
      checks++;
      if ({bus.x, bus.en, bus.chg} !== 10'h0)
        $display("FAIL reset_hold x=%h en=%b chg=%b want 00/0/0", bus.x, bus.en, bus.chg);
      else passes++;
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (bus.x !== ((k >= 6) ? 8'hFF : 8'h00) || bus.en !== (k >= 6) || bus.chg !== (k == 6))
        $display("FAIL reset_release k=%0d x=%h en=%b chg=%b want x=%h en=%b chg=%b",
                 k, bus.x, bus.en, bus.chg, (k >= 6) ? 8'hFF : 8'h00, k >= 6, k == 6);
      else passes++;
    end
  endtask

  task automatic test_step();
    settle();
    bus.sw = 8'h81;
    for (int k = 0; k <= 8; k++) begin
      tick();
      checks++;
      if (bus.x !== ((k >= 5) ? 8'h81 : 8'h00) || bus.chg !== (k == 5))
        $display("FAIL step k=%0d x=%h chg=%b want x=%h chg=%b",
                 k, bus.x, bus.chg, (k >= 5) ? 8'h81 : 8'h00, k == 5);
      else passes++;
    end
  endtask

  task automatic test_bounce();
    int nchg;
    settle();
    for (int k = 0; k < 14; k++) begin
      bus.sw[3] = (k < 8) && ((k % 4) < 2);
      tick();
      checks++;
      if (bus.x !== 8'h00 || bus.chg !== 1'b0)
        $display("FAIL bounce_reject k=%0d x=%h chg=%b want x=00 chg=0", k, bus.x, bus.chg);
      else passes++;
    end
    bus.sw[3] = 1'b1;
    nchg = 0;
    for (int k = 0; k <= 8; k++) begin
      tick();
      if (bus.chg === 1'b1) nchg++;
      checks++;
      if (bus.x !== ((k >= 5) ? 8'h08 : 8'h00))
        $display("FAIL bounce_hold k=%0d x=%h want %h", k, bus.x, (k >= 5) ? 8'h08 : 8'h00);
      else passes++;
    end
    checks++;
    if (nchg != 1) $display("FAIL bounce_chg_count got=%0d want=1", nchg);
    else passes++;
  endtask

  task automatic test_stagger();
    logic [7:0] ex;
    settle();
    for (int k = 0; k <= 9; k++) begin
      if (k == 0) bus.sw[7] = 1'b1;
      if (k == 2) bus.sw[0] = 1'b1;
      tick();
      ex = (k >= 7) ? 8'h81 : (k >= 5) ? 8'h80 : 8'h00;
      checks++;
      if (bus.x !== ex || bus.chg !== (k == 5 || k == 7))
        $display("FAIL stagger k=%0d x=%h chg=%b want x=%h chg=%b",
                 k, bus.x, bus.chg, ex, k == 5 || k == 7);
      else passes++;
    end
  endtask

  task automatic test_enable();
    settle();
    bus.en_sw = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      tick();
      checks++;
      if (bus.en !== (k >= 5) || bus.chg !== 1'b0 || bus.x !== 8'h00)
        $display("FAIL enable k=%0d en=%b chg=%b x=%h want en=%b chg=0 x=00",
                 k, bus.en, bus.chg, bus.x, k >= 5);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    settle();
    bus.sw[5] = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.x !== 8'h00) $display("FAIL rst_async x=%h want 00", bus.x);
    else passes++;
    repeat (2) begin
      tick();
      checks++;
      if (bus.x !== 8'h00 || bus.chg !== 1'b0)
        $display("FAIL rst_mid_hold x=%h chg=%b want 00/0", bus.x, bus.chg);
      else passes++;
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (bus.x !== ((k >= 6) ? 8'h20 : 8'h00) || bus.chg !== (k == 6))
        $display("FAIL rst_mid_release k=%0d x=%h chg=%b want x=%h chg=%b",
                 k, bus.x, bus.chg, (k >= 6) ? 8'h20 : 8'h00, k == 6);
      else passes++;
    end
  endtask

  task automatic test_random();
    int nerr;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    nerr = 0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(3) == 0) bus.sw[$urandom_range(7)] ^= 1'b1;
      if ($urandom_range(7) == 0) bus.en_sw ^= 1'b1;
      if ($urandom_range(15) == 0) bus.sw = 8'($urandom);
      tick();
      checks++;
      if (bus.x !== m_x || bus.en !== m_en || bus.chg !== m_chg) begin
        if (nerr < 10)
          $display("FAIL random n=%0d x=%h en=%b chg=%b want x=%h en=%b chg=%b",
                   n, bus.x, bus.en, bus.chg, m_x, m_en, m_chg);
        nerr++;
      end else passes++;
    end
  endtask

  initial begin
    bus.sw = 8'h00; bus.en_sw = 1'b0;
    test_reset();
    test_step();
    test_bounce();
    test_stagger();
    test_enable();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
